// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : issue_pkg
//  Description : Shared types and constants for the issue stage and the
//                issue-queue wakeup interface.
//                  issued_instr_t - one issued instruction. Only valid/dst
//                                   matter for wakeup.
//                  issue_data_t   - one cycle of issue: 4 alu, 2 mem,
//                                   1 branch, 1 mult.
//                  wake_req_t     - one wake broadcast (valid + preg id).
//  Revision    : 1.0 - initial release
// ============================================================================
package issue_pkg;

    localparam int PREG_W   = 7;
    localparam int WAKE_NUM = 12;

    // Fixed broadcast latencies, counted from issue cycle to wake cycle.
    localparam int LOAD_LAT = 3;
    localparam int MULT_LAT = 3;
    localparam int ALU_LAT  = 1;
    localparam int LATE_NUM = 4;

    // Where each producer lands on the wake bus.
    localparam int WAKE_ALU_BASE  = 0;
    localparam int WAKE_MEM_BASE  = 4;
    localparam int WAKE_BR        = 6;
    localparam int WAKE_MULT      = 7;
    localparam int WAKE_LATE_BASE = 8;

    // Elaboration fails with a divide-by-zero if the slot map and the
    // wake bus width ever disagree.
    localparam int LATE_NUM_CHECK = 1 / (((8 + LATE_NUM) == WAKE_NUM) ? 1 : 0);

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] dst;
        logic [3:0]        op;
    } issued_instr_t;

    typedef struct packed {
        issued_instr_t [3:0] alu_issue;
        issued_instr_t [1:0] mem_issue;
        issued_instr_t [0:0] branch_issue;
        issued_instr_t [0:0] mult_issue;
    } issue_data_t;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] id;
    } wake_req_t;

    // Preg 0 is never allocated, so it is never woken. Invalid wakes carry
    // id 0.
    function automatic wake_req_t to_wake(input issued_instr_t ins);
        wake_req_t w;
        w.valid = ins.valid && (ins.dst != '0);
        w.id    = w.valid ? ins.dst : '0;
        return w;
    endfunction

    // Delay-line depth for each issue-driven slot 0..7.
    function automatic int slot_lat(input int slot);
        if (slot == WAKE_MULT)
            return MULT_LAT;
        else if (slot >= WAKE_MEM_BASE && slot < WAKE_MEM_BASE + 2)
            return LOAD_LAT;
        else
            return ALU_LAT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wake_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : wake_delay_line
//  Description : Shift register delaying a wake request by DEPTH cycles.
//                  clk, rst_n - clock, asynchronous active-low reset
//                  clear      - kill every entry already in flight
//                  in         - wake request captured this cycle
//                  out        - wake request captured DEPTH cycles ago
//                               (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module wake_delay_line
    import issue_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clear,
    input  wake_req_t in,
    output wake_req_t out
);

    localparam int DEPTH_CHECK = 1 / ((DEPTH >= 1) ? 1 : 0);

    wake_req_t [DEPTH-1:0] stage_q;
    wake_req_t [DEPTH-1:0] stage_d;

    // clear kills only entries already in flight. The entry arriving this
    // cycle still loads into stage 0. A load that misses must not kill an
    // instruction issued on the same pipe in the same cycle. Callers that
    // need to discard the new entry as well, such as on a flush, drive in
    // to zero.
    always_comb begin
        stage_d[0] = in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = clear ? '0 : stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/wake_broadcast.sv
`default_nettype none
// ============================================================================
//  Module      : wake_broadcast
//  Description : Turns issued instructions into timed wake broadcasts for
//                the issue queues. Each issue port has a fixed-latency delay
//                line. Four late-writeback slots pass through with a single
//                register stage.
//                  clk, resetn - clock, asynchronous active-low reset
//                  flush       - kill all pending wakes and this cycle's
//                                inputs
//                  issue       - this cycle's issued instructions
//                  mem_cancel  - per mem pipe: kill that pipe's in-flight
//                                wakes
//                  late_wb     - late writebacks needing a wake
//                  wake        - registered broadcast, WAKE_NUM slots
//  Revision    : 1.0 - initial release
// ============================================================================
module wake_broadcast
    import issue_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  issue_data_t                  issue,
    input  logic [1:0]                   mem_cancel,
    input  wake_req_t [LATE_NUM-1:0]     late_wb,
    output wake_req_t [WAKE_NUM-1:0]     wake
);

    wake_req_t [7:0]          line_in;
    logic      [7:0]          line_clr;
    wake_req_t [LATE_NUM-1:0] late_q;
    wake_req_t [LATE_NUM-1:0] late_d;
    logic                     w_unused_ops;

    // The delay-line inputs are gated by flush, so a flush also discards
    // this cycle's issue.
    always_comb begin
        line_in  = '0;
        line_clr = {8{flush}};
        if (!flush) begin
            for (int k = 0; k < 4; k++) begin
                line_in[WAKE_ALU_BASE + k] = to_wake(issue.alu_issue[k]);
            end
            for (int p = 0; p < 2; p++) begin
                line_in[WAKE_MEM_BASE + p] = to_wake(issue.mem_issue[p]);
            end
            line_in[WAKE_BR]   = to_wake(issue.branch_issue[0]);
            line_in[WAKE_MULT] = to_wake(issue.mult_issue[0]);
        end
        for (int p = 0; p < 2; p++) begin
            line_clr[WAKE_MEM_BASE + p] = flush | mem_cancel[p];
        end
    end

    generate
        for (genvar s = 0; s < 8; s++) begin : g_line
            wake_delay_line #(
                .DEPTH (slot_lat(s))
            ) u_line (
                .clk   (clk),
                .rst_n (resetn),
                .clear (line_clr[s]),
                .in    (line_in[s]),
                .out   (wake[s])
            );
        end
    endgenerate

    // Late writebacks are not filtered on dst==0; those producers already
    // know the target is real. id is still zeroed when valid is low.
    always_comb begin
        late_d = '0;
        for (int i = 0; i < LATE_NUM; i++) begin
            if (!flush && late_wb[i].valid) begin
                late_d[i] = late_wb[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            late_q <= '0;
        end else begin
            late_q <= late_d;
        end
    end

    generate
        for (genvar i = 0; i < LATE_NUM; i++) begin : g_late
            assign wake[WAKE_LATE_BASE + i] = late_q[i];
        end
    endgenerate

    // Opcode fields ride along on the issue bus but play no part in wakeup.
    always_comb begin
        w_unused_ops = 1'b0;
        for (int k = 0; k < 4; k++) w_unused_ops = w_unused_ops ^ (^issue.alu_issue[k].op);
        for (int p = 0; p < 2; p++) w_unused_ops = w_unused_ops ^ (^issue.mem_issue[p].op);
        w_unused_ops = w_unused_ops ^ (^issue.branch_issue[0].op) ^ (^issue.mult_issue[0].op);
    end

endmodule
`default_nettype wire

// File: tb/tb_wake_broadcast.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wake_broadcast
//  Description : Self-checking bench for wake_broadcast. Table-driven
//                vectors exercise the single-cycle slots. Hand-written
//                sequences cover reset, the fixed latencies, back-to-back
//                issue, load cancel and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wake_broadcast;
    import issue_pkg::*;

    logic                     clk = 1'b0;
    logic                     resetn = 1'b0;
    logic                     flush = 1'b0;
    issue_data_t              issue = '0;
    logic [1:0]               mem_cancel = '0;
    wake_req_t [LATE_NUM-1:0] late_wb = '0;
    wake_req_t [WAKE_NUM-1:0] wake;

    int n_tests = 0;
    int n_fail  = 0;

    wake_broadcast dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .issue      (issue),
        .mem_cancel (mem_cancel),
        .late_wb    (late_wb),
        .wake       (wake)
    );

    always #5 clk = ~clk;

    // One cycle of single-cycle-slot stimulus and the expected wake mask
    // for the following cycle.
    typedef struct {
        logic [3:0]              alu_v;
        logic [3:0][PREG_W-1:0]  alu_d;
        logic                    br_v;
        logic [PREG_W-1:0]       br_d;
        logic [3:0]              late_v;
        logic [3:0][PREG_W-1:0]  late_d;
        logic [WAKE_NUM-1:0]     exp_mask;
    } vec_t;

    vec_t vecs [6];

    function automatic wake_req_t wr(input logic [PREG_W-1:0] id);
        wake_req_t w;
        w.valid = 1'b1;
        w.id    = id;
        return w;
    endfunction

    task automatic check(input string name, input wake_req_t [WAKE_NUM-1:0] exp);
        n_tests++;
        if (wake !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, wake, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue      = '0;
        mem_cancel = '0;
        late_wb    = '0;
        flush      = 1'b0;
    endtask

    wake_req_t [WAKE_NUM-1:0] exp_w;

    initial begin
        //                alu_v    alu_d (lane3..0)             br   br_d  late_v   late_d (3..0)              mask
        vecs[0] = '{4'b0001, {7'd0, 7'd0, 7'd0, 7'd10},   1'b0, 7'd0,  4'b0000, {7'd0, 7'd0, 7'd0, 7'd0},     12'h001};
        vecs[1] = '{4'b1111, {7'd14, 7'd13, 7'd12, 7'd11}, 1'b1, 7'd15, 4'b1111, {7'd19, 7'd18, 7'd17, 7'd16}, 12'hF4F};
        vecs[2] = '{4'b0010, {7'd0, 7'd0, 7'd0, 7'd0},    1'b0, 7'd0,  4'b1000, {7'd50, 7'd0, 7'd0, 7'd0},    12'h800};
        vecs[3] = '{4'b1111, {7'd3, 7'd0, 7'd2, 7'd0},    1'b1, 7'd0,  4'b0000, {7'd33, 7'd0, 7'd0, 7'd0},    12'h00A};
        vecs[4] = '{4'b0000, {7'd5, 7'd5, 7'd5, 7'd5},    1'b0, 7'd9,  4'b0000, {7'd0, 7'd0, 7'd0, 7'd0},     12'h000};
        vecs[5] = '{4'b0000, {7'd0, 7'd0, 7'd0, 7'd0},    1'b0, 7'd0,  4'b0001, {7'd0, 7'd0, 7'd0, 7'd0},     12'h100};

        // ---------------- reset ----------------
        resetn = 1'b0;
        issue.alu_issue[0].valid = 1'b1;
        issue.alu_issue[0].dst   = 7'd5;
        step();
        check("reset_hold_a", '0);
        step();
        check("reset_hold_b", '0);
        resetn = 1'b1;
        issue  = '0;
        step();
        check("reset_release", '0);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 6; i++) begin
            idle();
            for (int k = 0; k < 4; k++) begin
                issue.alu_issue[k].valid = vecs[i].alu_v[k];
                issue.alu_issue[k].dst   = vecs[i].alu_d[k];
                issue.alu_issue[k].op    = 4'(k + 3);
                late_wb[k].valid         = vecs[i].late_v[k];
                late_wb[k].id            = vecs[i].late_d[k];
            end
            issue.branch_issue[0].valid = vecs[i].br_v;
            issue.branch_issue[0].dst   = vecs[i].br_d;
            step();
            exp_w = '0;
            for (int k = 0; k < 4; k++) begin
                if (vecs[i].exp_mask[k])     exp_w[k]     = wr(vecs[i].alu_d[k]);
                if (vecs[i].exp_mask[8 + k]) exp_w[8 + k] = wr(vecs[i].late_d[k]);
            end
            if (vecs[i].exp_mask[6]) exp_w[6] = wr(vecs[i].br_d);
            check($sformatf("vec%0d", i), exp_w);
        end
        idle();
        step();
        check("vec_drain", '0);

        // ---------------- fixed latency ----------------
        issue.alu_issue[2].valid  = 1'b1;
        issue.alu_issue[2].dst    = 7'd7;
        issue.mem_issue[1].valid  = 1'b1;
        issue.mem_issue[1].dst    = 7'd9;
        issue.mult_issue[0].valid = 1'b1;
        issue.mult_issue[0].dst   = 7'd12;
        step();
        idle();
        exp_w = '0; exp_w[2] = wr(7'd7);
        check("lat_alu", exp_w);
        step();
        check("lat_gap", '0);
        step();
        exp_w = '0; exp_w[5] = wr(7'd9); exp_w[7] = wr(7'd12);
        check("lat_mem_mult", exp_w);
        step();
        check("lat_one_cycle", '0);

        // ---------------- back-to-back mem ----------------
        for (int i = 0; i < 3; i++) begin
            issue.mem_issue[0].valid = 1'b1;
            issue.mem_issue[0].dst   = 7'(20 + i);
            step();
            if (i < 2) check($sformatf("b2b_pre%0d", i), '0);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            exp_w = '0; exp_w[4] = wr(7'(20 + i));
            check($sformatf("b2b_wake%0d", i), exp_w);
            step();
        end
        check("b2b_end", '0);

        // ---------------- load cancel ----------------
        issue.mem_issue[0].valid = 1'b1;
        issue.mem_issue[0].dst   = 7'd30;
        step();
        issue.mem_issue[0].dst   = 7'd31;
        issue.mem_issue[1].valid = 1'b1;
        issue.mem_issue[1].dst   = 7'd33;
        step();
        issue.mem_issue[1]       = '0;
        issue.mem_issue[0].dst   = 7'd32;
        mem_cancel               = 2'b01;
        step();
        idle();
        check("cancel_kill30", '0);
        step();
        exp_w = '0; exp_w[5] = wr(7'd33);
        check("cancel_kill31_pipe1_ok", exp_w);
        step();
        exp_w = '0; exp_w[4] = wr(7'd32);
        check("cancel_new_lives", exp_w);
        step();
        check("cancel_end", '0);

        // ---------------- flush ----------------
        issue.mult_issue[0].valid = 1'b1;
        issue.mult_issue[0].dst   = 7'd40;
        issue.mem_issue[1].valid  = 1'b1;
        issue.mem_issue[1].dst    = 7'd44;
        step();
        idle();
        flush                    = 1'b1;
        issue.alu_issue[0].valid = 1'b1;
        issue.alu_issue[0].dst   = 7'd41;
        late_wb[1].valid         = 1'b1;
        late_wb[1].id            = 7'd42;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("flush_c%0d", i), '0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wake_broadcast.md
Name: wake_broadcast

Overview:
- Producer side of the issue-queue wakeup interface: turns issued instructions into timed `wake_req_t` broadcasts on the WAKE_NUM (12) wake ports consumed by the issue queues.
- Each issue port gets a fixed-latency delay line, so a destination preg wakes its dependents exactly when the result becomes forwardable.
- Four extra slots pass through late, variable-latency writebacks (divide, load-miss refill).
- Sits between the issue stage and the issue queues, in parallel with register read.

Parameters:
- LOAD_LAT, 3, cycles from mem issue to wake broadcast (>=1)
- MULT_LAT, 3, cycles from mult issue to wake broadcast (>=1)
- ALU_LAT, 1, cycles from ALU/branch issue to wake broadcast (fixed 1; not overridable)
- LATE_NUM, 4, number of late-writeback pass-through slots (WAKE_NUM - 8)

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills all pending wakes
- issue  in  issue_data_t  this cycle's issued instructions (4 alu, 2 mem, 1 branch, 1 mult)
- mem_cancel  in  2  per mem pipe: load missed; kill that pipe's in-flight wakes
- late_wb  in  wake_req_t[LATE_NUM]  late writebacks needing a wake
- wake  out  wake_req_t[WAKE_NUM]  broadcast to issue queues, registered

Behaviour:
- Reset (resetn=0, async) and flush both clear every delay-line stage and every wake output.
  - Reset: outputs are 0 while resetn is low.
  - Flush sampled high in cycle C: wake is 0 in cycle C+1.
  - Any issue or late_wb presented in cycle C is discarded.
- Slot map:
  - wake[0..3] = alu_issue[0..3]
  - wake[4..5] = mem_issue[0..1]
  - wake[6] = branch_issue[0]
  - wake[7] = mult_issue[0]
  - wake[8..11] = late_wb[0..3]
- Capture rule: a port is captured when its valid=1 and dst != 0. Preg 0 is never allocated and never woken.
- Latency: an instruction captured in cycle T drives wake[s].valid=1 and wake[s].id=dst in cycle T+L.
  - L = ALU_LAT for ALU and branch slots.
  - L = LOAD_LAT for mem slots.
  - L = MULT_LAT for the mult slot.
  - The wake is high for exactly one cycle.
- Pipelining: every delay line accepts one new entry per cycle. Back-to-back issues produce back-to-back wakes; there is no backpressure.
- Late slots: late_wb[i] valid in cycle T -> wake[8+i] = late_wb[i] in cycle T+1. No dst==0 filter on these slots.
- mem_cancel[p] high in cycle C:
  - Clears every valid stage of mem pipe p's delay line, including the entry that would broadcast in C+1.
  - An instruction issued on that pipe in the same cycle C is still captured.
  - Pipe p's wake slot is 0 in C+1.
  - Cancel has no effect on other slots.
- Simultaneous events:
  - flush has priority over mem_cancel, issue and late_wb.
  - mem_cancel together with a new mem issue on the same pipe: the old entries die, the new entry lives.
- Deassertion of an invalid wake: id is don't-care. The implementation drives id=0 when valid=0 so traces compare cleanly.
- Non-wake fields of issued_instr_t are ignored.

Decomposition:
- issue_pkg gains:
  - LOAD_LAT, MULT_LAT, ALU_LAT, LATE_NUM
  - slot index constants WAKE_ALU_BASE=0, WAKE_MEM_BASE=4, WAKE_BR=6, WAKE_MULT=7, WAKE_LATE_BASE=8
  - a static check that 8 + LATE_NUM == WAKE_NUM
- One sub-module, wake_delay_line: parameter DEPTH.
  - Inputs: in (wake_req_t), clear.
  - Output: out (wake_req_t) delayed DEPTH cycles.
  - Reset and clear zero all stages.
  - Instantiated 8 times; DEPTH=1 for the late slots is written inline.

Test Plan:
- Reset: hold resetn=0 with issue alu_issue[0]={valid=1,dst=5}; release -> all wake valid=0 during reset and for one cycle after.
- Fixed latency: cycle 10 alu_issue[2].dst=7, mem_issue[1].dst=9, mult_issue.dst=12 -> wake[2]={1,7} @11, wake[5]={1,9} @13, wake[7]={1,12} @13, each one cycle only.
- Back-to-back: mem_issue[0] dst=20,21,22 in cycles 5,6,7 -> wake[4] ids 20,21,22 in cycles 8,9,10.
- Load cancel: mem_issue[0] dst=30 @5, dst=31 @6, mem_cancel[0]=1 and dst=32 @7 -> wake[4] 0 @8 and @9, {1,32} @10; wake[5] unaffected.
- Flush: mult dst=40 @3, flush=1 @4 with alu_issue[0].dst=41 and late_wb[1]={1,42} -> no wake for 40, 41 or 42 in cycles 5-7.
- Filters and late path: alu_issue[1]={valid=1,dst=0} @2 -> wake[1] 0 @3; late_wb[3]={1,50} @2 -> wake[11]={1,50} @3.
